// File: rtl/sdpram_fifo_pkg.sv
// sdpram_fifo_pkg: shared constants and sizing helpers for the sdpram-backed
// FIFO controller and its output buffer.
//   OUT_DEPTH      entries in the prefetch/output buffer
//   fifo_capacity  total words held: RAM words plus output buffer
//   level_width    bit width of the level port for a given RAM address width
package sdpram_fifo_pkg;

  localparam int unsigned OUT_DEPTH = 2;

  function automatic int unsigned fifo_capacity(input int unsigned word_depth);
    return (32'd1 << word_depth) + OUT_DEPTH;
  endfunction

  // level must represent 0..2**word_depth + 2, hence two extra bits.
  function automatic int unsigned level_width(input int unsigned word_depth);
    return word_depth + 2;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: 2-entry FIFO holding words prefetched from the sdpram.
//   clk, rst   clock, asynchronous active-high reset
//   i_push     write i_data at the tail (caller guarantees room)
//   i_data     word to store
//   i_pop      consumer takes the head; ignored while empty
//   o_valid    head entry is valid
//   o_data     head entry
//   o_count    number of stored entries (0..2)
module fifo_out_buf
  import sdpram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [OUT_DEPTH];
  logic                  r_wr_idx;
  logic                  r_rd_idx;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign w_pop = i_pop & (r_count != 2'd0);

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_idx] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_idx <= ~r_wr_idx;
      if (w_pop)  r_rd_idx <= ~r_rd_idx;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_idx];
  assign o_count = r_count;

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl: ready/valid FIFO whose storage is an external simple
// dual-port RAM (write port A, 1-cycle-latency read port B). Words are
// prefetched into a 2-entry output buffer so both sides sustain 1 word/cycle.
//   clk, reset          clock, asynchronous active-high reset
//   s_valid/s_data      push request and word; s_ready = RAM not full
//   m_valid/m_data      head of the output buffer; m_ready pops it
//   ram_addra/dina/wea/ena  sdpram write port
//   ram_addrb/enb/doutb     sdpram read port (doutb valid cycle after enb)
//   level               words held: RAM + in-flight read + output buffer
module sdpram_fifo_ctrl
  import sdpram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORD_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                s_valid,
  input  logic [DATA_WIDTH-1:0]               s_data,
  output logic                                s_ready,
  output logic                                m_valid,
  output logic [DATA_WIDTH-1:0]               m_data,
  input  logic                                m_ready,
  output logic [WORD_DEPTH-1:0]               ram_addra,
  output logic [DATA_WIDTH-1:0]               ram_dina,
  output logic                                ram_wea,
  output logic                                ram_ena,
  output logic [WORD_DEPTH-1:0]               ram_addrb,
  output logic                                ram_enb,
  input  logic [DATA_WIDTH-1:0]               ram_doutb,
  output logic [level_width(WORD_DEPTH)-1:0]  level
);

  localparam logic [WORD_DEPTH:0] RAM_FULL = {1'b1, {WORD_DEPTH{1'b0}}};

  logic [WORD_DEPTH:0]   r_ram_count;
  logic [WORD_DEPTH-1:0] r_wr_ptr;
  logic [WORD_DEPTH-1:0] r_rd_ptr;
  logic                  r_rd_inflight;
  logic [1:0]            w_out_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_read;
  logic [2:0]            w_occ;

  assign s_ready = (r_ram_count < RAM_FULL);
  assign w_push  = s_valid & s_ready & ~reset;
  assign w_pop   = m_valid & m_ready;

  // Issue a read only if the buffer slot it will land in is guaranteed free:
  // buffered + in-flight - popping-now must stay below the buffer depth.
  // Because r_ram_count is registered, a word written this cycle is never
  // read in the same cycle.
  assign w_occ  = {1'b0, w_out_count} + {2'b00, r_rd_inflight};
  assign w_read = ~reset && (r_ram_count != '0) && (w_occ < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_count   <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_read) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rd_inflight <= w_read;
      r_ram_count   <= r_ram_count + {{WORD_DEPTH{1'b0}}, w_push}
                                   - {{WORD_DEPTH{1'b0}}, w_read};
    end
  end

  assign ram_addra = r_wr_ptr;
  assign ram_dina  = s_data;
  assign ram_wea   = w_push;
  assign ram_ena   = w_push;
  assign ram_addrb = r_rd_ptr;
  assign ram_enb   = w_read;

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk     (clk),
    .rst     (reset),
    .i_push  (r_rd_inflight),
    .i_data  (ram_doutb),
    .i_pop   (w_pop),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_count (w_out_count)
  );

  assign level = {1'b0, r_ram_count}
               + {{(WORD_DEPTH+1){1'b0}}, r_rd_inflight}
               + {{WORD_DEPTH{1'b0}}, w_out_count};

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Testbench for sdpram_fifo_ctrl (DATA_WIDTH=32, WORD_DEPTH=2, capacity 6)
// with a behavioural sdpram attached.
module tb_sdpram_fifo_ctrl;
  import sdpram_fifo_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned WD = 2;

  logic          clk;
  logic          reset;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [WD-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_wea;
  logic          ram_ena;
  logic [WD-1:0] ram_addrb;
  logic          ram_enb;
  logic [DW-1:0] ram_doutb;
  logic [WD+1:0] level;

  int n_vec;
  int n_bad;

  sdpram_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .WORD_DEPTH (WD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_wea   (ram_wea),
    .ram_ena   (ram_ena),
    .ram_addrb (ram_addrb),
    .ram_enb   (ram_enb),
    .ram_doutb (ram_doutb),
    .level     (level)
  );

  // Behavioural simple dual-port RAM, 1-cycle read latency.
  logic [DW-1:0] ram_mem [4];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= ram_mem[ram_addrb];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        e_sready;
    logic        e_mvalid;
    logic [31:0] e_mdata;
    logic [3:0]  e_level;
    logic        e_wea;
    logic [1:0]  e_addra;
    logic        e_enb;
    logic [1:0]  e_addrb;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic sv, logic [31:0] sd, logic mr, logic e_sr,
                              logic e_mv, logic [31:0] e_md, logic [3:0] e_lv,
                              logic e_we, logic [1:0] e_aa, logic e_en, logic [1:0] e_ab);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.e_sready = e_sr; v.e_mvalid = e_mv;
    v.e_mdata = e_md; v.e_level = e_lv; v.e_wea = e_we; v.e_addra = e_aa;
    v.e_enb = e_en; v.e_addrb = e_ab;
    return v;
  endfunction

  int unsigned exp_q[$];
  int pushed;
  int popped;
  logic [31:0] exp_w;

  initial begin
    n_vec = 0;
    n_bad = 0;

    //        sv sd            mr sr mv mdata         lvl we aa en ab
    // single word
    vt.push_back(mk(1, 32'hDEADBEEF, 1, 1, 0, 32'h0,        0, 1, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,        1, 0, 0, 1, 0));
    vt.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,        1, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,        1, 1, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 0, 0, 0));
    // fill to full with m_ready low (wr_ptr/rd_ptr start at 1)
    vt.push_back(mk(1, 32'h1, 0, 1, 0, 32'h0, 0, 1, 1, 0, 0));
    vt.push_back(mk(1, 32'h2, 0, 1, 0, 32'h0, 1, 1, 2, 1, 1));
    vt.push_back(mk(1, 32'h3, 0, 1, 0, 32'h0, 2, 1, 3, 1, 2));
    vt.push_back(mk(1, 32'h4, 0, 1, 1, 32'h1, 3, 1, 0, 0, 0));
    vt.push_back(mk(1, 32'h5, 0, 1, 1, 32'h1, 4, 1, 1, 0, 0));
    vt.push_back(mk(1, 32'h6, 0, 1, 1, 32'h1, 5, 1, 2, 0, 0));
    vt.push_back(mk(1, 32'h7, 0, 0, 1, 32'h1, 6, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h8, 0, 0, 1, 32'h1, 6, 0, 0, 0, 0));
    // drain from full
    vt.push_back(mk(0, 32'h0, 1, 0, 1, 32'h1, 6, 0, 0, 1, 3));
    vt.push_back(mk(0, 32'h0, 1, 1, 1, 32'h2, 5, 0, 0, 1, 0));
    vt.push_back(mk(0, 32'h0, 1, 1, 1, 32'h3, 4, 0, 0, 1, 1));
    vt.push_back(mk(0, 32'h0, 1, 1, 1, 32'h4, 3, 0, 0, 1, 2));
    vt.push_back(mk(0, 32'h0, 1, 1, 1, 32'h5, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h0, 1, 1, 1, 32'h6, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 0));

    // ---- reset state, with a push attempted during reset
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h12345678;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_wea", 32'(ram_wea), 32'd0);
    chk("rst_ena", 32'(ram_ena), 32'd0);
    chk("rst_enb", 32'(ram_enb), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("rst_sready", 32'(s_ready), 32'd1);

    // ---- table vectors
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      s_valid = vt[i].sv;
      s_data  = vt[i].sd;
      m_ready = vt[i].mr;
      #1;
      chk($sformatf("v%0d_sready", i), 32'(s_ready), 32'(vt[i].e_sready));
      chk($sformatf("v%0d_mvalid", i), 32'(m_valid), 32'(vt[i].e_mvalid));
      chk($sformatf("v%0d_level", i),  32'(level),   32'(vt[i].e_level));
      chk($sformatf("v%0d_wea", i),    32'(ram_wea), 32'(vt[i].e_wea));
      chk($sformatf("v%0d_enb", i),    32'(ram_enb), 32'(vt[i].e_enb));
      if (vt[i].e_mvalid) chk($sformatf("v%0d_mdata", i), m_data, vt[i].e_mdata);
      if (vt[i].e_wea)    chk($sformatf("v%0d_addra", i), 32'(ram_addra), 32'(vt[i].e_addra));
      if (vt[i].e_enb)    chk($sformatf("v%0d_addrb", i), 32'(ram_addrb), 32'(vt[i].e_addrb));
    end
    chk("capacity_level", 32'(fifo_capacity(WD)), 32'd6);

    // ---- streaming 20 words with m_ready high; pointers wrap
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 40 && popped < 20; c++) begin
      @(negedge clk);
      s_valid = (pushed < 20);
      s_data  = 32'h100 + 32'(pushed);
      m_ready = 1'b1;
      #1;
      if (c < 3)       chk($sformatf("stream_lat_c%0d", c), 32'(m_valid), 32'd0);
      else if (c < 23) chk($sformatf("stream_steady_c%0d", c), 32'(m_valid), 32'd1);
      if (s_valid && s_ready) pushed++;
      if (m_valid && m_ready) begin
        chk($sformatf("stream_data%0d", popped), m_data, 32'h100 + 32'(popped));
        popped++;
      end
    end
    chk("stream_count", 32'(popped), 32'd20);

    // ---- random backpressure, 64 words
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 2000 && popped < 64; c++) begin
      @(negedge clk);
      s_valid = (pushed < 64);
      s_data  = 32'h200 + 32'(pushed);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (s_valid && s_ready) begin
        exp_q.push_back(32'(s_data));
        pushed++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_unexpected_pop", m_data, 32'hFFFFFFFF);
        end else begin
          exp_w = exp_q.pop_front();
          chk($sformatf("bp_data%0d", popped), m_data, exp_w);
        end
        popped++;
      end
    end
    chk("bp_count", 32'(popped), 32'd64);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("bp_empty_after", 32'(m_valid), 32'd0);
    chk("bp_level_after", 32'(level), 32'd0);

    // ---- reset mid-operation with level = 4
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 32'h300 + 32'(k);
      m_ready = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("mid_level_before", 32'(level), 32'd4);
    @(negedge clk);
    reset   = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("mid_rst_wea", 32'(ram_wea), 32'd0);
    chk("mid_rst_enb", 32'(ram_enb), 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("mid_post_mvalid", 32'(m_valid), 32'd0);
    chk("mid_post_level", 32'(level), 32'd0);
    chk("mid_post_sready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 32'hA5A5A5A5;
    #1;
    chk("mid_push_wea", 32'(ram_wea), 32'd1);
    chk("mid_push_addra", 32'(ram_addra), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      chk($sformatf("mid_mvalid_c%0d", c), 32'(m_valid), (c == 3) ? 32'd1 : 32'd0);
    end
    chk("mid_mdata", m_data, 32'hA5A5A5A5);
    @(negedge clk);
    #1;
    chk("mid_final_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
